// File: rtl/cargador_memi_pkg.sv
// Shared definitions for the run-time instruction loader: state encoding, memory geometry
// and the big-endian byte selector used by the write path.
package cargador_memi_pkg;

    localparam int MEM_BYTES  = 1000;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_B0   = 3'd2,
        ST_B1   = 3'd3,
        ST_B2   = 3'd4,
        ST_B3   = 3'd5,
        ST_FIN  = 3'd6
    } cargador_state_e;

    // Byte idx of a word in big-endian order: idx 0 is W[31:24], idx 3 is W[7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*(3-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/cargador_memi_if.sv
// Word stream from the program source into the loader: start pulse plus valid/ready word channel.
interface cargador_memi_if;
    logic        start;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        w_last;

    modport master (output start, output w_valid, output w_data, output w_last, input w_ready);
    modport slave  (input start, input w_valid, input w_data, input w_last, output w_ready);
endinterface

// File: rtl/cargador_memi.sv
// Loads 32-bit words into the byte-wide instruction memory as 4 big-endian byte writes.
// Optional word checksum output when CARGADOR_SUMA_EN is defined.
module cargador_memi
    import cargador_memi_pkg::*;
#(
    parameter int          DEPTH = MEM_BYTES,
    parameter int          AW    = 32,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic            clk,
    input  logic            rst,
    cargador_memi_if.slave  wif,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_dr_o,
    output logic [7:0]      mem_db_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            ovf_o,
`ifdef CARGADOR_SUMA_EN
    output logic [31:0]     suma_o,
`endif
    output logic [AW-1:0]   count_o
);

    cargador_state_e state_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   count_q;
    logic [31:0]     word_q;
    logic            last_q;
    logic            w_ready_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_dr_q;
    logic [7:0]      mem_db_q;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;
`ifdef CARGADOR_SUMA_EN
    logic [31:0]     suma_q;
`endif

    // Extra bit so a word ending exactly at the top of the address space cannot wrap the check.
    logic [AW:0] end_addr;
    assign end_addr = {1'b0, addr_q} + (AW+1)'(WORD_BYTES);

    // Byte to emit on the edge leaving the current byte state.
    logic [1:0] nxt_idx;
    always_comb begin
        nxt_idx = 2'd3;
        unique case (state_q)
            ST_B0:   nxt_idx = 2'd1;
            ST_B1:   nxt_idx = 2'd2;
            default: nxt_idx = 2'd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            w_ready_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_dr_q  <= '0;
            mem_db_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef CARGADOR_SUMA_EN
            suma_q    <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (wif.start) begin
                        state_q   <= ST_RECV;
                        addr_q    <= BASE;
                        count_q   <= '0;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        w_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef CARGADOR_SUMA_EN
                        suma_q    <= '0;
`endif
                    end
                end
                ST_RECV: begin
                    if (wif.w_valid && w_ready_q) begin
                        w_ready_q <= 1'b0;
                        word_q    <= wif.w_data;
                        last_q    <= wif.w_last;
                        if (end_addr > (AW+1)'(DEPTH)) begin
                            ovf_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            state_q  <= ST_B0;
                            mem_we_q <= 1'b1;
                            mem_dr_q <= addr_q;
                            mem_db_q <= word_byte(wif.w_data, 2'd0);
                        end
                    end
                end
                ST_B0, ST_B1, ST_B2: begin
                    state_q  <= (state_q == ST_B0) ? ST_B1 :
                                (state_q == ST_B1) ? ST_B2 : ST_B3;
                    mem_we_q <= 1'b1;
                    mem_dr_q <= addr_q + AW'(nxt_idx);
                    mem_db_q <= word_byte(word_q, nxt_idx);
                end
                ST_B3: begin
                    addr_q  <= addr_q + AW'(WORD_BYTES);
                    count_q <= count_q + AW'(1);
`ifdef CARGADOR_SUMA_EN
                    suma_q  <= suma_q + word_q;
`endif
                    if (last_q) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= ST_RECV;
                        w_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    w_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign wif.w_ready = w_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_dr_o    = mem_dr_q;
    assign mem_db_o    = mem_db_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign count_o     = count_q;
`ifdef CARGADOR_SUMA_EN
    assign suma_o      = suma_q;
`endif

endmodule

// File: tb/tb_cargador_memi.sv
// Directed bench for cargador_memi: one loader at BASE 0 and one at BASE 996 near the top of memory.
// Exercises the optional checksum when CARGADOR_SUMA_EN is defined.
module tb_cargador_memi;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cargador_memi_if ia ();
    cargador_memi_if ib ();

    logic          we_a, we_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [AW-1:0] dr_a, dr_b, cnt_a, cnt_b;
    logic [7:0]    db_a, db_b;
`ifdef CARGADOR_SUMA_EN
    logic [31:0]   suma_a, suma_b;
`endif

    cargador_memi #(.DEPTH(1000), .AW(AW), .BASE(32'd0)) dut_a (
        .clk(clk), .rst(rst), .wif(ia.slave),
        .mem_we_o(we_a), .mem_dr_o(dr_a), .mem_db_o(db_a),
        .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a),
`ifdef CARGADOR_SUMA_EN
        .suma_o(suma_a),
`endif
        .count_o(cnt_a)
    );

    cargador_memi #(.DEPTH(1000), .AW(AW), .BASE(32'd996)) dut_b (
        .clk(clk), .rst(rst), .wif(ib.slave),
        .mem_we_o(we_b), .mem_dr_o(dr_b), .mem_db_o(db_b),
        .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b),
`ifdef CARGADOR_SUMA_EN
        .suma_o(suma_b),
`endif
        .count_o(cnt_b)
    );

    // Instruction memories fed by each loader's byte port.
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];
    always @(posedge clk) begin
        if (we_a) mem_a[dr_a[9:0]] <= db_a;
        if (we_b) mem_b[dr_b[9:0]] <= db_b;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
    endtask

    // Offer one word on loader A and check the 4 byte writes that follow it.
    task automatic send_a(input logic [31:0] w, input logic last, input int base, input bit hold);
        logic [7:0] exp_b [4];
        exp_b[0] = w[31:24]; exp_b[1] = w[23:16]; exp_b[2] = w[15:8]; exp_b[3] = w[7:0];
        ia.w_data  = w;
        ia.w_last  = last;
        ia.w_valid = 1'b1;
        check("rdy_before_word", ia.w_ready, 1'b1);
        step();
        if (!hold) ia.w_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("byte_we", we_a, 1'b1);
            check("byte_addr", dr_a, 64'(base + n));
            check("byte_data", db_a, exp_b[n]);
            check("rdy_low_in_bytes", ia.w_ready, 1'b0);
            step();
        end
        $display("word %08h last=%0d base=%0d written", w, last, base);
    endtask

    initial begin
        ia.start = 0; ia.w_valid = 0; ia.w_data = '0; ia.w_last = 0;
        ib.start = 0; ib.w_valid = 0; ib.w_data = '0; ib.w_last = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_we", we_a, 1'b0);
        check("rst_ready", ia.w_ready, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_count", cnt_a, 0);
        check("rst_dr", dr_a, 0);
        check("rst_db", db_a, 0);

        // Single word with LAST
        start_a();
        check("start_busy", busy_a, 1'b1);
        send_a(32'h8C220004, 1'b1, 0, 1'b0);
        check("w1_done", done_a, 1'b1);
        check("w1_count", cnt_a, 1);
        check("w1_busy", busy_a, 1'b0);
        check("w1_mem0", mem_a[0], 8'h8C);
        check("w1_mem1", mem_a[1], 8'h22);
        check("w1_mem2", mem_a[2], 8'h00);
        check("w1_mem3", mem_a[3], 8'h04);

        // Asynchronous reset in the middle of a word (during B1)
        start_a();
        check("restart_done_clr", done_a, 1'b0);
        check("restart_count_clr", cnt_a, 0);
        ia.w_data = 32'hAABBCCDD; ia.w_last = 1'b1; ia.w_valid = 1'b1;
        step();
        ia.w_valid = 1'b0;
        step();
        check("midb1_we", we_a, 1'b1);
        check("midb1_addr", dr_a, 1);
        rst = 1'b1;
        #1;
        check("arst_we", we_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        check("arst_count", cnt_a, 0);
        check("arst_dr", dr_a, 0);
        step();
        rst = 1'b0;
        step();
        check("partial_mem0", mem_a[0], 8'hAA);
        check("partial_mem1_kept", mem_a[1], 8'h22);
        $display("reset mid-word: mem[0]=%02h mem[1]=%02h", mem_a[0], mem_a[1]);
        start_a();
        send_a(32'h11223344, 1'b1, 0, 1'b0);
        check("after_rst_count", cnt_a, 1);
        check("after_rst_done", done_a, 1'b1);

        // Three words back to back with W_VALID held high
        start_a();
        send_a(32'h01234567, 1'b0, 0, 1'b1);
        send_a(32'h89ABCDEF, 1'b0, 4, 1'b1);
        send_a(32'hDEADBEEF, 1'b1, 8, 1'b1);
        ia.w_valid = 1'b0;
        check("b2b_count", cnt_a, 3);
        check("b2b_done", done_a, 1'b1);
        check("b2b_ready_fin", ia.w_ready, 1'b0);
        check("b2b_mem5", mem_a[5], 8'hAB);
        check("b2b_mem11", mem_a[11], 8'hEF);

        // START together with W_VALID: start acts, no word taken; then gapped stream
        ia.w_data = 32'hCAFE0000; ia.w_last = 1'b0; ia.w_valid = 1'b1;
        start_a();
        check("start_valid_we", we_a, 1'b0);
        check("start_valid_count", cnt_a, 0);
        ia.w_valid = 1'b0;
        for (int g = 0; g < 8; g++) begin
            for (int c = 0; c < g; c++) begin
                check("gap_we", we_a, 1'b0);
                check("gap_ready", ia.w_ready, 1'b1);
                step();
            end
            send_a(32'h10203040 + 32'(g), (g == 7), 4*g, 1'b0);
        end
        check("gap_count", cnt_a, 8);
        check("gap_done", done_a, 1'b1);
        check("gap_mem0", mem_a[0], 8'h10);
        check("gap_mem3", mem_a[3], 8'h40);
        check("gap_mem23", mem_a[23], 8'h45);
        check("gap_mem31", mem_a[31], 8'h47);

        // Overflow near the top of memory (BASE 996)
        ib.start = 1'b1;
        step();
        ib.start = 1'b0;
        ib.w_data = 32'h01020304; ib.w_last = 1'b0; ib.w_valid = 1'b1;
        check("ovf_rdy1", ib.w_ready, 1'b1);
        step();
        ib.w_valid = 1'b0;
        check("ovf_first_addr", dr_b, 996);
        step(); step(); step();
        check("ovf_last_addr", dr_b, 999);
        step();
        check("ovf_rdy2", ib.w_ready, 1'b1);
        ib.w_data = 32'h05060708; ib.w_last = 1'b1; ib.w_valid = 1'b1;
        step();
        ib.w_valid = 1'b0;
        check("ovf_we", we_b, 1'b0);
        check("ovf_flag", ovf_b, 1'b1);
        check("ovf_done", done_b, 1'b0);
        check("ovf_count", cnt_b, 1);
        check("ovf_busy", busy_b, 1'b0);
        check("ovf_mem996", mem_b[996], 8'h01);
        check("ovf_mem999", mem_b[999], 8'h04);
        step();
        check("ovf_sticky", ovf_b, 1'b1);
        $display("overflow load: ovf=%0d done=%0d count=%0d", ovf_b, done_b, cnt_b);

`ifdef CARGADOR_SUMA_EN
        start_a();
        check("suma_clr", suma_a, 32'h0);
        send_a(32'hFFFFFFFF, 1'b0, 0, 1'b0);
        send_a(32'h00000002, 1'b1, 4, 1'b0);
        check("suma_wrap", suma_a, 32'h00000001);
        start_a();
        check("suma_restart_clr", suma_a, 32'h0);
        check("suma_b_excl_ovf", suma_b, 32'h01020304);
        $display("checksum load: suma=%08h", suma_a);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
